// File: rtl/bitonic_sort_engine_pkg.sv
// Shared register offsets, FSM state type and index helpers for the bitonic sort engine.
package bitonic_pkg;
    localparam logic [8:0] CTRL_OFS = 9'h000;
    localparam logic [8:0] STAT_OFS = 9'h004;
    localparam logic [8:0] CYC_OFS  = 9'h008;
    localparam logic [8:0] DATA_OFS = 9'h100;

    typedef enum logic {IDLE, SORT} state_t;

    function automatic int unsigned partner(input int unsigned i, input int unsigned j);
        return i ^ (32'd1 << j);
    endfunction

    // Ascending when bit k of the lower index is clear; a descending sort inverts every comparator.
    function automatic logic dir_up(input int unsigned i, input int unsigned k, input logic desc);
        return (((i >> k) & 32'd1) == 32'd0) ^ desc;
    endfunction
endpackage

// File: rtl/bitonic_sort_engine_if.sv
// CSR bus between a bus master and the bitonic sort engine.
interface bitonic_sort_engine_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, resp, rdata);
    modport slave  (input req, we, addr, wdata, output ack, resp, rdata);
endinterface

// File: rtl/bitonic_sort_engine_cmp_ex.sv
// Combinational compare-exchange cell: lo_o lands at the lower index, hi_o at its partner.
module bitonic_cmp_ex #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          up_i,
    output logic [DW-1:0] lo_o,
    output logic [DW-1:0] hi_o
);
    logic swap;

    // Strict comparisons keep equal keys in place.
    assign swap = up_i ? (a_i > b_i) : (a_i < b_i);
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;
endmodule

// File: rtl/bitonic_sort_engine.sv
// Bus-attached iterative bitonic sorter, one compare-exchange substage per clock.
// Define BITONIC_PERF_CNT_EN to add the saturating sort cycle counter at CYC.
module bitonic_sort_engine
    import bitonic_pkg::*;
#(
    parameter int          N_POW     = 3,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic                 clk_gen,
    input  logic                 srst,
    bitonic_sort_engine_if.slave bus,
    output logic                 irq_o
);
    localparam int N  = 2 ** N_POW;
    localparam int IW = N_POW;
    localparam int CW = $clog2(N_POW + 1);

    state_t        state_q;
    logic [DW-1:0] data_q [N];
    logic [DW-1:0] data_d [N];
    logic [CW-1:0] k_q;
    logic [CW-1:0] j_q;
    logic          desc_q;
    logic          done_q;
    logic          irq_q;
    logic          resp_q;
    logic [31:0]   rdata_q;
`ifdef BITONIC_PERF_CNT_EN
    logic [31:0]   cyc_q;
`endif

    logic          busy;
    logic          inWindow;
    logic          rdHit;
    logic          wrHit;
    logic          dataHit;
    logic          ctrlWr;
    logic          statWr;
    logic [8:0]    ofs;
    logic [IW-1:0] wordIdx;
    logic [31:0]   rdValue;
    logic          unusedBits;

    logic [IW-1:0] loIdx [N/2];
    logic [IW-1:0] hiIdx [N/2];
    logic [DW-1:0] cmpA  [N/2];
    logic [DW-1:0] cmpB  [N/2];
    logic          cmpUp [N/2];
    logic [DW-1:0] cmpLo [N/2];
    logic [DW-1:0] cmpHi [N/2];

    assign ofs        = bus.addr[8:0];
    assign inWindow   = bus.addr[31:9] == BASE_ADDR[31:9];
    assign rdHit      = bus.req && !bus.we && inWindow;
    assign wrHit      = bus.req && bus.we && inWindow;
    assign dataHit    = ofs[8] && ({26'd0, ofs[7:2]} < 32'(N));
    assign wordIdx    = ofs[IW+1:2];
    assign ctrlWr     = wrHit && (ofs[8:2] == CTRL_OFS[8:2]);
    assign statWr     = wrHit && (ofs[8:2] == STAT_OFS[8:2]);
    assign busy       = state_q == SORT;
    assign bus.ack    = bus.req;
    assign bus.resp   = resp_q;
    assign bus.rdata  = rdata_q;
    assign irq_o      = irq_q;
    assign unusedBits = ^{bus.addr[1:0], bus.wdata};

    // Index c of the comparator array maps to the c-th index with bit j clear.
    function automatic logic [IW-1:0] lowIndex(input int unsigned c, input int unsigned j);
        int unsigned low = c & ((32'd1 << j) - 32'd1);
        return IW'(((c >> j) << (j + 1)) | low);
    endfunction

    always_comb begin
        for (int c = 0; c < N/2; c++) begin
            loIdx[c] = lowIndex(c, 32'(j_q));
            hiIdx[c] = IW'(partner(32'(loIdx[c]), 32'(j_q)));
            cmpA[c]  = data_q[loIdx[c]];
            cmpB[c]  = data_q[hiIdx[c]];
            cmpUp[c] = dir_up(32'(loIdx[c]), 32'(k_q), desc_q);
        end
    end

    for (genvar g = 0; g < N/2; g++) begin : gCmp
        bitonic_cmp_ex #(.DW(DW)) uCmp (
            .a_i  (cmpA[g]),
            .b_i  (cmpB[g]),
            .up_i (cmpUp[g]),
            .lo_o (cmpLo[g]),
            .hi_o (cmpHi[g])
        );
    end

    always_comb begin
        data_d = data_q;
        for (int c = 0; c < N/2; c++) begin
            data_d[loIdx[c]] = cmpLo[c];
            data_d[hiIdx[c]] = cmpHi[c];
        end
    end

    always_comb begin
        rdValue = '0;
        if (ofs[8]) begin
            if (dataHit) rdValue = 32'(data_q[wordIdx]);
        end else if (ofs[8:2] == STAT_OFS[8:2]) begin
            rdValue = {29'd0, desc_q, done_q, busy};
        end
`ifdef BITONIC_PERF_CNT_EN
        else if (ofs[8:2] == CYC_OFS[8:2]) begin
            rdValue = cyc_q;
        end
`endif
    end

    // Control FSM, read port and buffer; the done-set on the final substage overrides a STAT clear.
    always_ff @(posedge clk_gen) begin
        if (srst) begin
            state_q <= IDLE;
            k_q     <= CW'(1);
            j_q     <= '0;
            desc_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            for (int e = 0; e < N; e++) data_q[e] <= '0;
`ifdef BITONIC_PERF_CNT_EN
            cyc_q   <= '0;
`endif
        end else begin
            irq_q  <= 1'b0;
            resp_q <= rdHit;
            if (rdHit) rdata_q <= rdValue;
            if (statWr) done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ctrlWr && bus.wdata[0]) begin
                        state_q <= SORT;
                        desc_q  <= bus.wdata[1];
                        done_q  <= 1'b0;
                        k_q     <= CW'(1);
                        j_q     <= '0;
`ifdef BITONIC_PERF_CNT_EN
                        cyc_q   <= '0;
`endif
                    end
                    if (wrHit && dataHit) data_q[wordIdx] <= bus.wdata[DW-1:0];
                end
                SORT: begin
                    data_q <= data_d;
`ifdef BITONIC_PERF_CNT_EN
                    if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
`endif
                    if (j_q != '0) begin
                        j_q <= j_q - CW'(1);
                    end else if (k_q < CW'(N_POW)) begin
                        k_q <= k_q + CW'(1);
                        j_q <= k_q;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitonic_sort_engine.sv
// Directed self-checking bench for bitonic_sort_engine (N=8, DW=32).
module tb_bitonic_sort_engine;
    import bitonic_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk_gen = 1'b0;
    logic        srst;
    logic        irq;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rdData;
    logic        rdResp;
    logic        ackSeen;
    logic [31:0] vec    [8];
    logic [31:0] expVec [8];
    logic [31:0] expCyc;
    int          cycles;
    logic        sawIrq;

    bitonic_sort_engine_if bus ();

    bitonic_sort_engine #(
        .N_POW     (3),
        .DW        (32),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_gen (clk_gen),
        .srst    (srst),
        .bus     (bus),
        .irq_o   (irq)
    );

    always #5 clk_gen = ~clk_gen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_gen);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = addr;
        bus.wdata = data;
        @(negedge clk_gen);
        bus.req   = 1'b0;
        bus.we    = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output logic gotResp);
        @(negedge clk_gen);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = addr;
        #1 ackSeen = bus.ack;
        @(negedge clk_gen);
        bus.req  = 1'b0;
        gotResp  = bus.resp;
        data     = bus.rdata;
    endtask

    task automatic applyStimulus(input logic [31:0] values [8]);
        for (int i = 0; i < 8; i++) busWrite(BASE + 32'(DATA_OFS) + 32'(4 * i), values[i]);
    endtask

    task automatic checkBuffer(input logic [31:0] expected [8], input string tag);
        for (int i = 0; i < 8; i++) begin
            busRead(BASE + 32'(DATA_OFS) + 32'(4 * i), rdData, rdResp);
            checkOutput($sformatf("%s[%0d]", tag, i), rdData, expected[i]);
        end
    endtask

    task automatic checkStat(input logic [31:0] expected, input string tag);
        busRead(BASE + 32'(STAT_OFS), rdData, rdResp);
        checkOutput({tag, "_resp"}, 32'(rdResp), 32'd1);
        checkOutput(tag, rdData, expected);
    endtask

    task automatic waitIrq(input int limit, output int n);
        n = 0;
        while (irq !== 1'b1 && n < limit) begin
            @(negedge clk_gen);
            n++;
        end
    endtask

    initial begin
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        srst      = 1'b1;
`ifdef BITONIC_PERF_CNT_EN
        expCyc = 32'd6;
`else
        expCyc = 32'd0;
`endif

        // Reset state
        repeat (2) @(negedge clk_gen);
        srst = 1'b0;
        checkOutput("reset_resp", 32'(bus.resp), 32'd0);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkStat(32'd0, "reset_stat");
        checkOutput("ack_follows_req", 32'(ackSeen), 32'd1);
        expVec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        checkBuffer(expVec, "reset_data");

        // Ascending sort, latency and single irq pulse
        vec = '{32'd5, 32'd1, 32'd7, 32'd3, 32'd8, 32'd2, 32'd6, 32'd4};
        applyStimulus(vec);
        busWrite(BASE + 32'(CTRL_OFS), 32'd1);
        waitIrq(20, cycles);
        checkOutput("asc_latency", 32'(cycles), 32'd6);
        @(negedge clk_gen);
        checkOutput("irq_one_pulse", 32'(irq), 32'd0);
        expVec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        checkBuffer(expVec, "asc_data");
        checkStat(32'd2, "asc_stat");
        busRead(BASE + 32'(CYC_OFS), rdData, rdResp);
        checkOutput("cyc_value", rdData, expCyc);

        // Descending sort restarted while done=1
        applyStimulus(vec);
        busWrite(BASE + 32'(CTRL_OFS), 32'd3);
        waitIrq(20, cycles);
        checkOutput("desc_latency", 32'(cycles), 32'd6);
        expVec = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        checkBuffer(expVec, "desc_data");
        checkStat(32'd6, "desc_stat");

        // Duplicate keys, ascending
        vec = '{32'd3, 32'd3, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0};
        applyStimulus(vec);
        busWrite(BASE + 32'(CTRL_OFS), 32'd1);
        waitIrq(20, cycles);
        checkOutput("dup_latency", 32'(cycles), 32'd6);
        expVec = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3};
        checkBuffer(expVec, "dup_data");
        checkStat(32'd2, "dup_stat");
        busWrite(BASE + 32'(STAT_OFS), 32'hFFFF_FFFF);
        checkStat(32'd0, "stat_clear_done");

        // DATA write and restart while busy are dropped
        vec = '{32'd5, 32'd1, 32'd7, 32'd3, 32'd8, 32'd2, 32'd6, 32'd4};
        applyStimulus(vec);
        busWrite(BASE + 32'(CTRL_OFS), 32'd1);
        busWrite(BASE + 32'(DATA_OFS), 32'd99);
        busWrite(BASE + 32'(CTRL_OFS), 32'd3);
        checkStat(32'd1, "busy_stat");
        waitIrq(20, cycles);
        checkOutput("busy_irq_seen", 32'(irq), 32'd1);
        expVec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        checkBuffer(expVec, "busy_data");
        checkStat(32'd2, "busy_final_stat");

        // Window decode boundaries
        busRead(BASE + 32'h0F0, rdData, rdResp);
        checkOutput("hole_resp", 32'(rdResp), 32'd1);
        checkOutput("hole_data", rdData, 32'd0);
        busRead(BASE + 32'h120, rdData, rdResp);
        checkOutput("data8_data", rdData, 32'd0);
        busRead(BASE + 32'(CTRL_OFS), rdData, rdResp);
        checkOutput("ctrl_reads_zero", rdData, 32'd0);
        busRead(BASE + 32'h200, rdData, rdResp);
        checkOutput("outside_no_resp", 32'(rdResp), 32'd0);
        busWrite(BASE + 32'h300, 32'd77);
        busRead(BASE + 32'(DATA_OFS), rdData, rdResp);
        checkOutput("outside_write_ignored", rdData, 32'd1);

        // Synchronous reset during the third sort cycle
        applyStimulus(vec);
        busWrite(BASE + 32'(CTRL_OFS), 32'd1);
        repeat (2) @(negedge clk_gen);
        srst = 1'b1;
        @(negedge clk_gen);
        srst = 1'b0;
        sawIrq = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_gen);
            if (irq === 1'b1) sawIrq = 1'b1;
        end
        checkOutput("abort_no_irq", 32'(sawIrq), 32'd0);
        checkStat(32'd0, "abort_stat");
        expVec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        checkBuffer(expVec, "abort_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
